plot_grid_receiver: RTL

Consumes the pixel-plot stream produced by the snake game backend: x/y/colour, with a one-cycle plot strobe per pixel. It buffers the stream in a small FIFO and folds each pixel into a tile-resolution board memory. The game logic can then query tile occupancy for collision and food checks. It sits beside the VGA adapter on the same plot bus, as a second reader of that stream.

---
 rtl/plot_grid_receiver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/plot_grid_receiver.sv
// Second reader of the snake plot bus: buffers pixels in a small FIFO, folds them into a
// tile-resolution colour board and answers tile occupancy queries for the game logic.
module plot_grid_receiver #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TILE_SHIFT = 2,
    parameter int unsigned GRID_W     = 40,
    parameter int unsigned GRID_H     = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       plot_in,
    output logic       in_full,
    output logic       overflow,
    input  logic       clear_start,
    output logic       busy,
    input  logic       q_valid,
    input  logic [5:0] q_x,
    input  logic [4:0] q_y,
    output logic       q_ready,
    output logic       r_valid,
    output logic [2:0] r_colour
);
    localparam int unsigned Cells = GRID_W * GRID_H;
    localparam int unsigned AddrW = $clog2(Cells);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    typedef enum logic [1:0] {StClear, StIdle, StQwait} state_e;

    // Pixel FIFO, entries packed as {x, y, colour}
    logic [17:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, fifo_nonempty;

    assign in_full       = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign push          = plot_in && !in_full && !clear_start;
    assign overflow      = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PtrW'(push);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        count_d    = count_q + CntW'(push) - CntW'(pop);
        overflow_d = overflow_q || (plot_in && in_full);
        if (clear_start) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {x_in, y_in, colour_in};
    end

    // Head-of-FIFO tile address
    logic [17:0]      head;
    logic [7:0]       pop_tx;
    logic [6:0]       pop_ty;
    logic             pop_in_grid;
    logic [AddrW-1:0] pop_addr;

    assign head        = fifo_mem[rd_ptr_q];
    assign pop_tx      = head[17:10] >> TILE_SHIFT;
    assign pop_ty      = head[9:3] >> TILE_SHIFT;
    assign pop_in_grid = (32'(pop_tx) < GRID_W) && (32'(pop_ty) < GRID_H);
    assign pop_addr    = AddrW'(32'(pop_ty) * GRID_W + 32'(pop_tx));

    logic             q_in_grid;
    logic [AddrW-1:0] q_addr;

    assign q_in_grid = (32'(q_x) < GRID_W) && (32'(q_y) < GRID_H);
    assign q_addr    = AddrW'(32'(q_y) * GRID_W + 32'(q_x));

    // Single-port board RAM
    logic [2:0]       board_mem [Cells];
    logic             ram_we, ram_re;
    logic [AddrW-1:0] ram_addr;
    logic [2:0]       ram_wdata, ram_rdata_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            board_mem[ram_addr] <= ram_wdata;
        end else if (ram_re) begin
            ram_rdata_q <= board_mem[ram_addr];
        end
    end

    state_e           state_q, state_d;
    logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
    logic             last_query_q, last_query_d;
    logic             q_wall_q, q_wall_d;
    logic             r_valid_q, r_valid_d;
    logic [2:0]       r_colour_q, r_colour_d;

    assign r_valid  = r_valid_q;
    assign r_colour = r_colour_q;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_query_d = last_query_q;
        q_wall_d     = q_wall_q;
        r_valid_d    = 1'b0;
        r_colour_d   = r_colour_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_addr     = clr_cnt_q;
        ram_wdata    = 3'b000;
        pop          = 1'b0;
        q_ready      = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            StClear: begin
                busy   = 1'b1;
                ram_we = 1'b1;
                if (clr_cnt_q == AddrW'(Cells - 1)) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                // After a query, a pending pixel gets the next slot so queries cannot starve it
                q_ready = !clear_start && !(fifo_nonempty && last_query_q);
                if (q_valid && q_ready) begin
                    ram_re       = q_in_grid;
                    ram_addr     = q_addr;
                    q_wall_d     = !q_in_grid;
                    last_query_d = 1'b1;
                    state_d      = StQwait;
                end else if (fifo_nonempty && !clear_start) begin
                    pop          = 1'b1;
                    last_query_d = 1'b0;
                    ram_we       = pop_in_grid;
                    ram_addr     = pop_addr;
                    ram_wdata    = head[2:0];
                end
            end
            StQwait: begin
                state_d    = StIdle;
                r_valid_d  = 1'b1;
                r_colour_d = q_wall_q ? 3'b111 : ram_rdata_q;
            end
            default: state_d = StClear;
        endcase
        if (clear_start) begin
            state_d    = StClear;
            clr_cnt_d  = '0;
            r_valid_d  = 1'b0;
            r_colour_d = r_colour_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            last_query_q <= 1'b0;
            q_wall_q     <= 1'b0;
            r_valid_q    <= 1'b0;
            r_colour_q   <= 3'b000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_query_q <= last_query_d;
            q_wall_q     <= q_wall_d;
            r_valid_q    <= r_valid_d;
            r_colour_q   <= r_colour_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule
